io_host_bridge: RTL
===================

IO_HOST_BRIDGE -- requirements
Module: io_host_bridge

Interface
REQ-001 SHALL have parameter FLASH_GAP, default 1: idle cycles inserted after each flash-word inputReady pulse (0..15).
REQ-002 SHALL have parameter DATA_W, default 16: parallel bus width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 hostValid  input  1  host word available on hostData.
REQ-006 hostReady  output  1  bridge accepts hostData this cycle.
REQ-007 hostData  input  16  word from host: program word in flash session, input operand in run.
REQ-008 flashStart  input  1  one-cycle pulse in IDLE that starts a flash session.
REQ-009 flashLen  input  8  sampled with flashStart; session length is flashLen+1 words (1..256).
REQ-010 runStart  input  1  one-cycle pulse in IDLE that enters run mode without flashing.
REQ-011 abort  input  1  return to IDLE from any state.
REQ-012 flashEnable  output  1  to core; high for the whole flash session.
REQ-013 inputReady  output  1  to core; qualifies parallelIn.
REQ-014 inputWaiting  input  1  from core; core blocked on an input instruction.
REQ-015 parallelIn  output  16  to core; registered data word.
REQ-016 parallelOut  input  16  from core; output port value.
REQ-017 outValid  output  1  one-cycle pulse when a new core output is captured.
REQ-018 outData  output  16  captured core output, valid with outValid and held afterwards.
REQ-019 flashDone  output  1  one-cycle pulse after the last flash word.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, FL_WAIT, FL_PUSH, FL_GAP, RUN_IDLE and RUN_PRESENT.
REQ-022 IDLE SHALL behave as follows: flashStart goes to FL_WAIT, loads the word counter with flashLen and raises flashEnable; runStart goes to RUN_IDLE; flashStart takes priority over runStart; both are ignored outside IDLE.
REQ-023 FL_WAIT SHALL drive hostReady=1; on hostValid it registers hostData into parallelIn and goes to FL_PUSH.
REQ-024 FL_PUSH SHALL drive inputReady=1 for exactly one cycle, then go to FL_GAP (or straight to the counter check if FLASH_GAP=0).
REQ-025 After the gap, with counter≠0 the bridge SHALL decrement the counter and go to FL_WAIT; with counter=0 it SHALL drop flashEnable, pulse flashDone and go to RUN_IDLE.
REQ-026 If hostValid is absent during a flash session, the bridge SHALL stall indefinitely in FL_WAIT with flashEnable held high.
REQ-027 RUN_IDLE SHALL drive hostReady = inputWaiting; on hostValid&&inputWaiting it registers hostData into parallelIn and goes to RUN_PRESENT.
REQ-028 RUN_PRESENT SHALL hold inputReady=1 and parallelIn stable until inputWaiting is sampled low, then go to RUN_IDLE with inputReady=0 (four-phase handshake).
REQ-029 The bridge SHALL NOT raise hostReady in FL_PUSH, FL_GAP or RUN_PRESENT, so at most one host word is in flight.
REQ-030 While in RUN_IDLE or RUN_PRESENT, the bridge SHALL register parallelOut each cycle; when it differs from the prior sample, it SHALL update outData and pulse outValid one cycle later. Consecutive equal outputs are deliberately not reported.
REQ-031 On entry to run mode, the bridge SHALL load the compare register with the current parallelOut, so that no spurious outValid is produced.
REQ-032 abort SHALL force IDLE on the next edge and clear inputReady, flashEnable and hostReady in that same cycle (combinational gating); a word presented with abort high is not consumed.
REQ-033 An abort mid-flash SHALL NOT pulse flashDone.
REQ-034 The counter SHALL be 8 bits; flashLen=255 yields 256 words with no wrap.

Reset
REQ-035 reset low SHALL asynchronously force IDLE and clear parallelIn, outData, the counter and the compare register to 0; all outputs SHALL be 0.
REQ-036 Release of reset SHALL be synchronised externally; the first active state change occurs no earlier than the first edge after release.

Structure
REQ-037 Package confusedcore_pkg SHALL hold the DATA_W and ROM-depth constants and the bridge state enum type.
REQ-038 The parallelOut change detector (sample register, compare, outValid/outData) SHALL be a sub-module named io_out_monitor.

Verification
REQ-039 flashStart with flashLen=2 and 3 host words 0x1001/0x2002/0x3003 SHALL produce 3 single-cycle inputReady pulses with matching parallelIn, each followed by FLASH_GAP idle cycles, with flashEnable high throughout, then flashDone, then RUN_IDLE.
REQ-040 In run mode, core raises inputWaiting and host offers 0x00AB: parallelIn=0x00AB and inputReady held until inputWaiting falls, then inputReady=0 next cycle.
REQ-041 parallelOut sequence 5,5,9 SHALL produce exactly one outValid with outData=9 (entry value 5 not reported).
REQ-042 abort asserted in FL_WAIT after one of four words SHALL clear flashEnable same cycle, give IDLE next edge, and no flashDone.
REQ-043 reset asserted during RUN_PRESENT SHALL drop inputReady immediately and clear parallelIn to 0; no further output until flashStart or runStart.
REQ-044 flashLen=255 SHALL produce exactly 256 inputReady pulses before flashDone.

Source files
------------

// File: rtl/confusedcore_pkg.sv
//------------------------------------------------------------------------------
// Module   : confusedcore_pkg
// Purpose  : Shared constants and the host-bridge state type for the core I/O
//            slice (bus width, program ROM depth, flash word counter width).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package confusedcore_pkg;

   localparam int DATA_W    = 16;                  // parallel bus width
   localparam int ROM_DEPTH = 256;                 // program words per flash
   localparam int CNT_W     = $clog2(ROM_DEPTH);   // flash word counter width

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      FL_WAIT     = 3'd1,
      FL_PUSH     = 3'd2,
      FL_GAP      = 3'd3,
      RUN_IDLE    = 3'd4,
      RUN_PRESENT = 3'd5
   } bridge_state_t;

endpackage

`default_nettype wire

// File: rtl/io_out_monitor.sv
//------------------------------------------------------------------------------
// Module   : io_out_monitor
// Purpose  : Watches the core output port while the bridge is in run mode and
//            reports each change of value as a one-cycle valid pulse with the
//            new value held on the data output afterwards.
// Ports    : clk, reset (async, active-low)
//            i_active  - bridge is in a run-mode state
//            i_sample  - core parallel output port
//            o_valid   - one-cycle pulse, new value captured
//            o_data    - last captured value
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_out_monitor #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_active,
   input  logic [DATA_W-1:0] i_sample,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic              r_active_d;
   logic [DATA_W-1:0] r_cmp;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_active_d <= 1'b0;
         r_cmp      <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
      end else begin
         r_active_d <= i_active;
         r_valid    <= 1'b0;
         if (i_active) begin
            // The compare register follows the port every run cycle. In the
            // first run cycle it is only loaded, so the value already on the
            // port when run mode starts is never reported as a change.
            r_cmp <= i_sample;
            if (r_active_d && (i_sample != r_cmp)) begin
               r_data  <= i_sample;
               r_valid <= 1'b1;
            end
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/io_host_bridge.sv
//------------------------------------------------------------------------------
// Module   : io_host_bridge
// Purpose  : Bridges a host word stream to the core. In a flash session the
//            host words are pushed to the core as program words with
//            flashEnable high. In run mode the host words answer core input
//            requests over a four-phase handshake. Core output changes are
//            reported back through io_out_monitor.
// Ports    : clk, reset (async, active-low)
//            hostValid/hostReady/hostData  - host word channel
//            flashStart/flashLen/runStart  - session control, sampled in IDLE
//            abort                         - return to IDLE from any state
//            flashEnable/inputReady/parallelIn - to core
//            inputWaiting/parallelOut          - from core
//            outValid/outData                  - captured core output
//            flashDone                         - pulse after last flash word
//            busy                              - not in IDLE
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_host_bridge
   import confusedcore_pkg::*;
#(
   parameter int FLASH_GAP = 1,
   parameter int DATA_W    = confusedcore_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hostValid,
   output logic              hostReady,
   input  logic [DATA_W-1:0] hostData,
   input  logic              flashStart,
   input  logic [CNT_W-1:0]  flashLen,
   input  logic              runStart,
   input  logic              abort,
   output logic              flashEnable,
   output logic              inputReady,
   input  logic              inputWaiting,
   output logic [DATA_W-1:0] parallelIn,
   input  logic [DATA_W-1:0] parallelOut,
   output logic              outValid,
   output logic [DATA_W-1:0] outData,
   output logic              flashDone,
   output logic              busy
);

   // Gap counter is loaded with FLASH_GAP-1 and the session check fires
   // when it reaches zero, giving exactly FLASH_GAP cycles in FL_GAP.
   localparam logic [3:0] c_GAP_LOAD = 4'((FLASH_GAP > 0) ? (FLASH_GAP - 1) : 0);

   bridge_state_t     r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [3:0]        r_gap;
   logic [DATA_W-1:0] r_pin;
   logic              r_flash_en;
   logic              r_input_rdy;
   logic              r_flash_done;

   logic              w_flash_check;
   logic              w_run_active;

   // End of the post-push gap: decide between the next word and session end.
   assign w_flash_check = ((r_state == FL_PUSH) && (FLASH_GAP == 0)) ||
                          ((r_state == FL_GAP)  && (r_gap == 4'd0));

   assign w_run_active  = (r_state == RUN_IDLE) || (r_state == RUN_PRESENT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_gap        <= 4'd0;
         r_pin        <= '0;
         r_flash_en   <= 1'b0;
         r_input_rdy  <= 1'b0;
         r_flash_done <= 1'b0;
      end else begin
         r_flash_done <= 1'b0;
         if (abort) begin
            // No flashDone here: an aborted session is not a completed one.
            r_state     <= IDLE;
            r_flash_en  <= 1'b0;
            r_input_rdy <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (flashStart) begin
                     r_state    <= FL_WAIT;
                     r_cnt      <= flashLen;
                     r_flash_en <= 1'b1;
                  end else if (runStart) begin
                     r_state <= RUN_IDLE;
                  end
               end
               FL_WAIT: begin
                  if (hostValid) begin
                     r_pin       <= hostData;
                     r_input_rdy <= 1'b1;
                     r_state     <= FL_PUSH;
                  end
               end
               FL_PUSH: begin
                  r_input_rdy <= 1'b0;
                  if (FLASH_GAP > 0) begin
                     r_state <= FL_GAP;
                     r_gap   <= c_GAP_LOAD;
                  end
               end
               FL_GAP: begin
                  if (r_gap != 4'd0) begin
                     r_gap <= r_gap - 4'd1;
                  end
               end
               RUN_IDLE: begin
                  if (hostValid && inputWaiting) begin
                     r_pin       <= hostData;
                     r_input_rdy <= 1'b1;
                     r_state     <= RUN_PRESENT;
                  end
               end
               RUN_PRESENT: begin
                  if (!inputWaiting) begin
                     r_input_rdy <= 1'b0;
                     r_state     <= RUN_IDLE;
                  end
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase

            // Counter holds the number of words still to come after the
            // current one, so zero here means the session is complete.
            if (w_flash_check) begin
               if (r_cnt != '0) begin
                  r_cnt   <= r_cnt - CNT_W'(1);
                  r_state <= FL_WAIT;
               end else begin
                  r_flash_en   <= 1'b0;
                  r_flash_done <= 1'b1;
                  r_state      <= RUN_IDLE;
               end
            end
         end
      end
   end

   // abort gates the core/host strobes in the same cycle so that a word
   // presented alongside abort is never consumed.
   assign hostReady   = !abort && ((r_state == FL_WAIT) ||
                                   ((r_state == RUN_IDLE) && inputWaiting));
   assign flashEnable = r_flash_en  && !abort;
   assign inputReady  = r_input_rdy && !abort;
   assign parallelIn  = r_pin;
   assign flashDone   = r_flash_done;
   assign busy        = (r_state != IDLE);

   io_out_monitor #(
      .DATA_W (DATA_W)
   ) u_out_monitor (
      .clk      (clk),
      .reset    (reset),
      .i_active (w_run_active),
      .i_sample (parallelOut),
      .o_valid  (outValid),
      .o_data   (outData)
   );

endmodule

`default_nettype wire
